// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input debouncer:
//   - deb_state_e : per-channel debounce FSM state encoding (2 bits)
//   - default clock / timing constants and the cycle counts derived from them
//   - params_legal(): parameter legality helper used by the top level
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } deb_state_e;

    localparam int CLK_FREQ_HZ   = 32'd100_000_000;
    localparam int DEBOUNCE_MS   = 32'd10;
    localparam int LONG_MS       = 32'd1000;
    localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 32'd1000;

    // 10 ms and 1 s at the default clock
    localparam int DEBOUNCE_CYCLES_DEF = CYCLES_PER_MS * DEBOUNCE_MS;
    localparam int LONG_CYCLES_DEF     = CYCLES_PER_MS * LONG_MS;

    // The debounce window needs at least two cycles, and a long press must
    // outlast the debounce window.
    function automatic logic params_legal(input int deb_cycles, input int long_cycles);
        return (deb_cycles >= 32'sd2) && (long_cycles > deb_cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One input channel: 2-FF synchroniser, 4-state debounce FSM with a stability
// counter, and a long-press counter. All outputs are registered.
// Ports:
//   clk_i          system clock (rising edge)
//   rst_i          asynchronous reset, active high
//   din_i          raw asynchronous pin level
//   dout_o         debounced level
//   rise_o         one-cycle pulse on dout 0->1
//   fall_o         one-cycle pulse on dout 1->0
//   long_press_o   one-cycle pulse when dout has been high LONG_CYCLES cycles
//   held_o         high from the long_press pulse until dout falls
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_press_o,
    output logic held_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic          sync1_q, sync2_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_q, long_d;
    logic          held_q, held_d;

    // Two-flop synchroniser; sync2_q is the only path from the pin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state and debounce counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: the counter holds how many consecutive cycles the
    // synchronised level has differed from the accepted level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = CHECK_HI;
                    cnt_d   = CW'(1'b1);
                end else begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            end
            CHECK_HI: begin
                if (!sync2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    state_d = CHECK_HI;
                    cnt_d   = cnt_q + CW'(1'b1);
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = CHECK_LO;
                    cnt_d   = CW'(1'b1);
                end else begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end
            end
            CHECK_LO: begin
                if (sync2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    state_d = CHECK_LO;
                    cnt_d   = cnt_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values: pulses fire on the same edge the accepted level
    // changes. The long counter follows the registered level, so a bounce in
    // CHECK_LO leaves it running; it saturates instead of wrapping.
    always_comb begin
        rise_d = (state_q == CHECK_HI) && sync2_q && (cnt_q == CNT_LAST);
        fall_d = (state_q == CHECK_LO) && !sync2_q && (cnt_q == CNT_LAST);

        if (rise_d) begin
            dout_d = 1'b1;
        end else if (fall_d) begin
            dout_d = 1'b0;
        end else begin
            dout_d = dout_q;
        end

        if (!dout_q) begin
            long_cnt_d = '0;
        end else if (long_cnt_q == LONG_MAX) begin
            long_cnt_d = long_cnt_q;
        end else begin
            long_cnt_d = long_cnt_q + LW'(1'b1);
        end

        // No long press is reported on the very edge the level falls.
        long_d = dout_q && (long_cnt_q == LONG_LAST) && !fall_d;

        if (fall_d) begin
            held_d = 1'b0;
        end else if (long_d) begin
            held_d = 1'b1;
        end else begin
            held_d = held_q;
        end
    end

    // Registered outputs and long-press counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            long_cnt_q <= '0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

    assign dout_o       = dout_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign long_press_o = long_q;
    assign held_o       = held_q;

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Conditions N_CH raw switch/button pins: one independent debounce_channel
// per pin.
// Ports:
//   sysClk     system clock (rising edge)
//   sysRst     asynchronous reset, active high
//   din        raw asynchronous pin levels [N_CH]
//   dout       debounced levels [N_CH]
//   rise       one-cycle pulses on dout 0->1 [N_CH]
//   fall       one-cycle pulses on dout 1->0 [N_CH]
//   longPress  one-cycle pulses after dout high LONG_CYCLES [N_CH]
//   held       high from longPress until dout falls [N_CH]
// -----------------------------------------------------------------------------
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic            sysClk,
    input  logic            sysRst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] longPress,
    output logic [N_CH-1:0] held
);

    if (!params_legal(DEBOUNCE_CYCLES, LONG_CYCLES)) begin : g_param_error
        $error("input_debouncer: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk_i       (sysClk),
            .rst_i       (sysRst),
            .din_i       (din[i]),
            .dout_o      (dout[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i]),
            .long_press_o(longPress[i]),
            .held_o      (held[i])
        );
    end

endmodule
